// File: rtl/msk_hpc3_feeder.sv
// ---------------------------------------------------------------------------
// msk_hpc3_feeder
//   Issue stage in front of a masked HPC3 AND gadget (one d-share bit).
//   Joins an operand-sharing stream with a fresh-randomness stream, presents
//   the gadget's ina/inb/rnd from registers, generates ina_prev, and captures
//   the gadget output sharing into a credit-protected output FIFO.
//   The gadget cannot stall, so a launch is only issued while the FIFO is
//   guaranteed to have room for every operation already in flight.
//
//   Handshakes: a transfer happens on a rising edge where valid & ready are
//   both high; ready never depends on the same channel's valid, and a valid
//   source holds its data until the transfer.
//
// Configuration macro:
//   HPC3_FEED_ZEROIZE_EN  defined: g_ina/g_inb/g_rnd load 0 on cycles with no
//                         launch. Undefined: they hold the last launched values.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_a, in_b, in_valid   operand sharings / valid;   in_ready  out
//   rnd_in, rnd_valid      fresh randomness / valid;   rnd_ready out
//   g_ina, g_ina_prev,     registered drives to the gadget
//   g_inb, g_rnd
//   g_out                  gadget output sharing (1 cycle after g_ina)
//   out_c, out_valid       FIFO head / valid;          out_ready in
// ---------------------------------------------------------------------------
module msk_hpc3_feeder #(
  parameter int d          = 2,
  parameter int FIFO_DEPTH = 3,
  localparam int hpc3rnd   = d * (d - 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [d-1:0]       in_a,
  input  logic [d-1:0]       in_b,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [hpc3rnd-1:0] rnd_in,
  input  logic               rnd_valid,
  output logic               rnd_ready,
  output logic [d-1:0]       g_ina,
  output logic [d-1:0]       g_ina_prev,
  output logic [d-1:0]       g_inb,
  output logic [hpc3rnd-1:0] g_rnd,
  input  logic [d-1:0]       g_out,
  output logic [d-1:0]       out_c,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  // Pipeline occupancy: L = operands sitting on the gadget inputs,
  // G = gadget output valid this cycle.
  logic               l_valid_q, g_valid_q;
  logic [d-1:0]       g_ina_q, g_ina_prev_q, g_inb_q;
  logic [hpc3rnd-1:0] g_rnd_q;

  logic [d-1:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [d-1:0]       last_head_q;

  logic [3:0]         occ;
  logic               space, accept, push, pop;

  // Credits: every op already launched will land in the FIFO, so count them
  // as occupied. A pop in this cycle only frees a credit from the next cycle.
  assign occ       = 4'(cnt_q) + 4'(l_valid_q) + 4'(g_valid_q);
  assign space     = ~rst & (occ < 4'(FIFO_DEPTH));
  assign in_ready  = space & rnd_valid;
  assign rnd_ready = space & in_valid;
  assign accept    = in_valid & rnd_valid & space;

  assign push      = g_valid_q;
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid & out_ready;
  // When empty, keep presenting the last head that was popped.
  assign out_c     = out_valid ? mem_q[rd_ptr_q] : last_head_q;

  assign g_ina      = g_ina_q;
  assign g_ina_prev = g_ina_prev_q;
  assign g_inb      = g_inb_q;
  assign g_rnd      = g_rnd_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l_valid_q    <= 1'b0;
      g_valid_q    <= 1'b0;
      g_ina_q      <= '0;
      g_ina_prev_q <= '0;
      g_inb_q      <= '0;
      g_rnd_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      last_head_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      l_valid_q    <= accept;
      g_valid_q    <= l_valid_q;
      g_ina_prev_q <= g_ina_q;
      if (accept) begin
        g_ina_q <= in_a;
        g_inb_q <= in_b;
        g_rnd_q <= rnd_in;
      end
`ifdef HPC3_FEED_ZEROIZE_EN
      else begin
        g_ina_q <= '0;
        g_inb_q <= '0;
        g_rnd_q <= '0;
      end
`endif
      if (push) mem_q[wr_ptr_q] <= g_out;
      if (pop)  last_head_q <= mem_q[rd_ptr_q];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_msk_hpc3_feeder.sv
// ---------------------------------------------------------------------------
// tb_msk_hpc3_feeder
//   Bench for msk_hpc3_feeder (d=2, FIFO_DEPTH=3) with a behavioural gadget
//   stand-in that re-masks the product of the unmasked inputs.
//   Reference model: every accepted op becomes one expected result that must
//   appear at the FIFO head three cycles after acceptance (or later under
//   backpressure), in order; at most FIFO_DEPTH ops may be outstanding.
// ---------------------------------------------------------------------------
module tb_msk_hpc3_feeder;

  localparam int D     = 2;
  localparam int DEPTH = 3;
  localparam int R     = D * (D - 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [D-1:0] in_a = '0, in_b = '0;
  logic         in_valid = 1'b0, rnd_valid = 1'b0, out_ready = 1'b0;
  logic [R-1:0] rnd_in = '0;
  logic         in_ready, rnd_ready, out_valid;
  logic [D-1:0] g_ina, g_ina_prev, g_inb, g_out, out_c;
  logic [R-1:0] g_rnd;

  msk_hpc3_feeder #(.d(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_a(in_a), .in_b(in_b), .in_valid(in_valid), .in_ready(in_ready),
    .rnd_in(rnd_in), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .g_ina(g_ina), .g_ina_prev(g_ina_prev), .g_inb(g_inb), .g_rnd(g_rnd),
    .g_out(g_out),
    .out_c(out_c), .out_valid(out_valid), .out_ready(out_ready)
  );

  // Gadget stand-in: one-cycle latency, fresh output masking each cycle.
  always @(posedge clk) begin
    logic m;
    m = 1'($urandom);
    g_out <= {m ^ ((^g_ina) & (^g_inb)), m};
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [0:0]   exp_q[$];   // expected unmasked result per outstanding op
  int           rdy_q[$];   // earliest cycle that op may be at the FIFO head
  int           cyc = 0;
  int           acc_total = 0;
  bit           mon_en = 1'b0;
  logic [D-1:0] m_ina = '0, m_ina_prev = '0, m_inb = '0;
  logic [R-1:0] m_rnd = '0;

  // Values sampled mid-cycle, applied to the model on the next rising edge.
  bit           s_rst, s_acc, s_pop;
  logic [D-1:0] s_a, s_b;
  logic [R-1:0] s_r;

  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_ov;
      bit room;
      exp_ov = (exp_q.size() > 0) && (rdy_q[0] <= cyc);
      room   = !rst && (exp_q.size() < DEPTH);
      check_eq("in_ready",   in_ready,   room && rnd_valid);
      check_eq("rnd_ready",  rnd_ready,  room && in_valid);
      check_eq("out_valid",  out_valid,  exp_ov);
      check_eq("g_ina",      g_ina,      m_ina);
      check_eq("g_inb",      g_inb,      m_inb);
      check_eq("g_rnd",      g_rnd,      m_rnd);
      check_eq("g_ina_prev", g_ina_prev, m_ina_prev);
      s_pop = out_valid && out_ready;
      if (s_pop && exp_ov) check_eq("result", ^out_c, exp_q[0]);
      s_rst = rst;
      s_acc = in_valid && in_ready && rnd_valid && rnd_ready;
      s_a = in_a; s_b = in_b; s_r = rnd_in;
    end
  end

  always @(posedge clk) begin
    if (mon_en) begin
      if (s_rst) begin
        exp_q.delete();
        rdy_q.delete();
        m_ina = '0; m_inb = '0; m_rnd = '0; m_ina_prev = '0;
      end else begin
        if (s_pop && exp_q.size() > 0 && rdy_q[0] <= cyc) begin
          void'(exp_q.pop_front());
          void'(rdy_q.pop_front());
        end
        m_ina_prev = m_ina;
        if (s_acc) begin
          exp_q.push_back((^s_a) & (^s_b));
          rdy_q.push_back(cyc + 3);
          acc_total++;
          m_ina = s_a; m_inb = s_b; m_rnd = s_r;
        end else begin
`ifdef HPC3_FEED_ZEROIZE_EN
          m_ina = '0; m_inb = '0; m_rnd = '0;
`endif
        end
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer n operations; each is held until accepted. rnd_valid may gap.
  task automatic send_ops(input int n, input bit rnd_gaps, input bit rand_ready);
    int sent = 0;
    int guard = 0;
    bit need_new = 1'b1;
    while (sent < n && guard < 2000) begin
      @(posedge clk); #1;
      if (need_new) begin
        in_a = D'($urandom); in_b = D'($urandom); rnd_in = R'($urandom);
        need_new = 1'b0;
      end
      in_valid  = 1'b1;
      rnd_valid = rnd_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (in_valid && in_ready && rnd_valid) begin
        sent++;
        need_new = 1'b1;
      end
      guard++;
    end
    if (sent < n) check_eq("send_timeout", sent, n);
    @(posedge clk); #1;
    in_valid = 1'b0; rnd_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) check_eq("drain_timeout", exp_q.size(), 0);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    // Reset, with both valids high to show ready stays low during rst.
    in_valid = 1'b1; rnd_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_c", out_c, 0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; rnd_valid = 1'b0;
    idle_cycles(2);

    // Single op: a=01, b=10, rnd=11 -> ^out_c = 1 at t+3.
    out_ready = 1'b1;
    in_a = 2'b01; in_b = 2'b10; rnd_in = 2'b11; in_valid = 1'b1; rnd_valid = 1'b1;
    @(negedge clk);
    check_eq("single_acc", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; rnd_valid = 1'b0;
    @(negedge clk); check_eq("single_t1_ov", out_valid, 0);
    @(negedge clk); check_eq("single_t2_ov", out_valid, 0);
    @(negedge clk); check_eq("single_t3_ov", out_valid, 1);
    check_eq("single_val", ^out_c, 1);
    idle_cycles(3);
    check_eq("single_empty", out_valid, 0);

    // Idle after launch (zeroize build clears gadget drives; model covers both).
    idle_cycles(2);

    // Back-to-back 8 ops with out_ready=1.
    send_ops(8, 1'b0, 1'b0);
    drain();

    // Backpressure: out_ready=0, offer 5 ops -> only 3 taken.
    out_ready = 1'b0;
    base = acc_total;
    fork
      send_ops(5, 1'b0, 1'b0);
      begin
        repeat (12) @(posedge clk);
        @(negedge clk);
        check_eq("bp_accepted", acc_total - base, 3);
        check_eq("bp_in_ready", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check_eq("bp_total", acc_total - base, 5);

    // Randomness missing: no accept, in_ready=0, rnd_ready=1.
    idle_cycles(1);
    in_a = 2'b11; in_b = 2'b01; in_valid = 1'b1; rnd_valid = 1'b0;
    @(negedge clk);
    check_eq("nornd_in_ready", in_ready, 0);
    check_eq("nornd_rnd_ready", rnd_ready, 1);
    @(posedge clk); #1;
    rnd_valid = 1'b1; rnd_in = 2'b10;
    @(negedge clk);
    check_eq("rnd_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; rnd_valid = 1'b0;
    drain();

    // Reset one cycle after an accept: op must vanish.
    in_a = 2'b01; in_b = 2'b01; rnd_in = 2'b01; in_valid = 1'b1; rnd_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; rnd_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rstmid_g_ina", g_ina, 0);
    check_eq("rstmid_g_rnd", g_rnd, 0);
    check_eq("rstmid_out_c", out_c, 0);
    idle_cycles(6);
    check_eq("rstmid_no_out", out_valid, 0);

    // Randomized traffic with gaps on both sides.
    send_ops(60, 1'b1, 1'b1);
    drain();
    idle_cycles(3);
    check_eq("final_empty", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
